pacman_motion_engine: RTL

- Consumes the latched player direction request (direction_t) and moves the Pac-Man sprite across the maze tile grid, one pixel per move_tick.
- Turns and forward moves are checked against the maze wall map through a request/valid query port.
- Sits between the direction controller and the sprite renderer / collision logic.
- Turns are buffered: a requested direction is taken at the next tile centre where it is legal.

---
 rtl/pacman_motion_engine.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pacman_motion_engine.sv
// pacman_motion_engine
//
// Moves the Pac-Man sprite across the maze tile grid, one pixel per move_tick_i.
// Direction requests are buffered in a pending register and taken at the next tile
// centre where the wall map says the neighbour tile is free. Reversals mid-tile need
// no query. Both axes wrap around (tunnel).
//
// direction encoding (dir_req_i / heading_o):
//   0 = IDLE, 1 = UP, 2 = DOWN, 3 = LEFT, 4 = RIGHT
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   restart_i           synchronous re-init to start state (highest priority)
//   move_tick_i         one pixel step opportunity
//   dir_req_i           requested direction from the direction controller
//   wall_req_o          wall query strobe, held until wall_valid_i
//   wall_tx_o/wall_ty_o queried tile, stable while wall_req_o is high
//   wall_valid_i        query answer valid (one cycle)
//   wall_is_wall_i      1 = queried tile is blocked, sampled with wall_valid_i
//   tile_x_o/tile_y_o   current tile
//   pos_x_o/pos_y_o     pixel position = tile * TILE_W + offset
//   heading_o           current travel direction
//   moving_o            heading is not IDLE and not blocked
//   tile_entered_o      one-cycle pulse when the tile index changes
//   dbg_drop_cnt_o      saturating count of move_ticks dropped while a query is
//                       outstanding; present only with PACMAN_MOTION_DEBUG_EN defined
module pacman_motion_engine #(
  parameter int unsigned TILE_W   = 8,
  parameter int unsigned GRID_W   = 28,
  parameter int unsigned GRID_H   = 31,
  parameter int unsigned START_TX = 13,
  parameter int unsigned START_TY = 23
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      restart_i,
  input  logic                      move_tick_i,
  input  logic [2:0]                dir_req_i,
  output logic                      wall_req_o,
  output logic [$clog2(GRID_W)-1:0] wall_tx_o,
  output logic [$clog2(GRID_H)-1:0] wall_ty_o,
  input  logic                      wall_valid_i,
  input  logic                      wall_is_wall_i,
  output logic [$clog2(GRID_W)-1:0] tile_x_o,
  output logic [$clog2(GRID_H)-1:0] tile_y_o,
  output logic [9:0]                pos_x_o,
  output logic [9:0]                pos_y_o,
  output logic [2:0]                heading_o,
  output logic                      moving_o,
  output logic                      tile_entered_o
`ifdef PACMAN_MOTION_DEBUG_EN
  ,
  output logic [15:0]               dbg_drop_cnt_o
`endif
);

  localparam int unsigned TxW  = $clog2(GRID_W);
  localparam int unsigned TyW  = $clog2(GRID_H);
  localparam int unsigned OffW = $clog2(TILE_W);

  localparam logic [2:0] DirIdle  = 3'd0;
  localparam logic [2:0] DirUp    = 3'd1;
  localparam logic [2:0] DirDown  = 3'd2;
  localparam logic [2:0] DirLeft  = 3'd3;
  localparam logic [2:0] DirRight = 3'd4;

  localparam logic [TxW-1:0]  TxStart = TxW'(START_TX);
  localparam logic [TxW-1:0]  TxMax   = TxW'(GRID_W - 1);
  localparam logic [TxW-1:0]  TxOne   = TxW'(1);
  localparam logic [TyW-1:0]  TyStart = TyW'(START_TY);
  localparam logic [TyW-1:0]  TyMax   = TyW'(GRID_H - 1);
  localparam logic [TyW-1:0]  TyOne   = TyW'(1);
  localparam logic [OffW-1:0] OffMax  = OffW'(TILE_W - 1);
  localparam logic [OffW-1:0] OffOne  = OffW'(1);

  typedef enum logic [1:0] {StWait, StQTurn, StQAhead} state_e;

  state_e          state_q;
  logic [2:0]      heading_q, pending_q, turn_dir_q;
  logic [TxW-1:0]  tile_x_q, wall_tx_q;
  logic [TyW-1:0]  tile_y_q, wall_ty_q;
  logic [OffW-1:0] off_x_q, off_y_q;
  logic            moving_q, wall_req_q, tile_entered_q;

  function automatic logic is_opposite(logic [2:0] a, logic [2:0] b);
    return (a == DirUp    && b == DirDown)  || (a == DirDown  && b == DirUp) ||
           (a == DirLeft  && b == DirRight) || (a == DirRight && b == DirLeft);
  endfunction

  logic            centred, reverse, answer, do_step, step_cross;
  logic [TxW-1:0]  x_inc, x_dec, nb_tx, step_tx;
  logic [TyW-1:0]  y_inc, y_dec, nb_ty, step_ty;
  logic [OffW-1:0] step_offx, step_offy;
  logic [2:0]      qry_dir, step_dir;

  assign centred = (off_x_q == '0) && (off_y_q == '0);
  assign reverse = is_opposite(pending_q, heading_q);

  // Tunnel wrap on both axes, shared by neighbour queries and steps.
  assign x_inc = (tile_x_q == TxMax) ? '0 : tile_x_q + TxOne;
  assign x_dec = (tile_x_q == '0) ? TxMax : tile_x_q - TxOne;
  assign y_inc = (tile_y_q == TyMax) ? '0 : tile_y_q + TyOne;
  assign y_dec = (tile_y_q == '0) ? TyMax : tile_y_q - TyOne;

  always_comb begin
    qry_dir = (state_q == StQTurn) ? turn_dir_q : heading_q;
    nb_tx   = tile_x_q;
    nb_ty   = tile_y_q;
    case (qry_dir)
      DirUp:    nb_ty = y_dec;
      DirDown:  nb_ty = y_inc;
      DirLeft:  nb_tx = x_dec;
      DirRight: nb_tx = x_inc;
      default:  ;
    endcase

    // A granted turn or a mid-tile reversal steps in the new direction.
    if (state_q == StQTurn) begin
      step_dir = turn_dir_q;
    end else if (state_q == StWait && reverse) begin
      step_dir = pending_q;
    end else begin
      step_dir = heading_q;
    end

    step_tx    = tile_x_q;
    step_ty    = tile_y_q;
    step_offx  = off_x_q;
    step_offy  = off_y_q;
    step_cross = 1'b0;
    case (step_dir)
      DirRight: begin
        if (off_x_q == OffMax) begin
          step_offx  = '0;
          step_tx    = x_inc;
          step_cross = 1'b1;
        end else begin
          step_offx = off_x_q + OffOne;
        end
      end
      DirLeft: begin
        if (off_x_q == '0) begin
          step_offx  = OffMax;
          step_tx    = x_dec;
          step_cross = 1'b1;
        end else begin
          step_offx = off_x_q - OffOne;
        end
      end
      DirDown: begin
        if (off_y_q == OffMax) begin
          step_offy  = '0;
          step_ty    = y_inc;
          step_cross = 1'b1;
        end else begin
          step_offy = off_y_q + OffOne;
        end
      end
      DirUp: begin
        if (off_y_q == '0) begin
          step_offy  = OffMax;
          step_ty    = y_dec;
          step_cross = 1'b1;
        end else begin
          step_offy = off_y_q - OffOne;
        end
      end
      default: ;
    endcase

    // wall_valid_i only counts while a query is actually on the bus.
    answer  = (state_q != StWait) && wall_req_q && wall_valid_i;
    do_step = (state_q == StWait && move_tick_i && !centred) || (answer && !wall_is_wall_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StWait;
      heading_q      <= DirIdle;
      pending_q      <= DirIdle;
      turn_dir_q     <= DirIdle;
      tile_x_q       <= TxStart;
      tile_y_q       <= TyStart;
      off_x_q        <= '0;
      off_y_q        <= '0;
      wall_tx_q      <= '0;
      wall_ty_q      <= '0;
      moving_q       <= 1'b0;
      wall_req_q     <= 1'b0;
      tile_entered_q <= 1'b0;
    end else if (restart_i) begin
      state_q        <= StWait;
      heading_q      <= DirIdle;
      pending_q      <= DirIdle;
      turn_dir_q     <= DirIdle;
      tile_x_q       <= TxStart;
      tile_y_q       <= TyStart;
      off_x_q        <= '0;
      off_y_q        <= '0;
      wall_tx_q      <= '0;
      wall_ty_q      <= '0;
      moving_q       <= 1'b0;
      wall_req_q     <= 1'b0;
      tile_entered_q <= 1'b0;
    end else begin
      tile_entered_q <= 1'b0;
      if (dir_req_i != DirIdle) pending_q <= dir_req_i;

      if (do_step) begin
        tile_x_q       <= step_tx;
        tile_y_q       <= step_ty;
        off_x_q        <= step_offx;
        off_y_q        <= step_offy;
        tile_entered_q <= step_cross;
      end

      unique case (state_q)
        StWait: begin
          if (move_tick_i) begin
            if (!centred) begin
              moving_q <= 1'b1;
              if (reverse) heading_q <= pending_q;
            end else if (pending_q != DirIdle && pending_q != heading_q) begin
              turn_dir_q <= pending_q;
              state_q    <= StQTurn;
            end else if (heading_q != DirIdle) begin
              state_q <= StQAhead;
            end
          end
        end
        StQTurn, StQAhead: begin
          if (!wall_req_q) begin
            // Raise the strobe one cycle after entering the query state.
            wall_req_q <= 1'b1;
            wall_tx_q  <= nb_tx;
            wall_ty_q  <= nb_ty;
          end else if (wall_valid_i) begin
            wall_req_q <= 1'b0;
            if (!wall_is_wall_i) begin
              if (state_q == StQTurn) heading_q <= turn_dir_q;
              moving_q <= 1'b1;
              state_q  <= StWait;
            end else if (state_q == StQTurn && heading_q != DirIdle) begin
              state_q <= StQAhead;
            end else begin
              // Blocked: keep heading so the sprite faces the wall.
              moving_q <= 1'b0;
              state_q  <= StWait;
            end
          end
        end
        default: state_q <= StWait;
      endcase
    end
  end

`ifdef PACMAN_MOTION_DEBUG_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (restart_i) begin
      drop_cnt_q <= '0;
    end else if (move_tick_i && state_q != StWait && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign dbg_drop_cnt_o = drop_cnt_q;
`endif

  assign wall_req_o     = wall_req_q;
  assign wall_tx_o      = wall_tx_q;
  assign wall_ty_o      = wall_ty_q;
  assign tile_x_o       = tile_x_q;
  assign tile_y_o       = tile_y_q;
  assign pos_x_o        = (10'(tile_x_q) << OffW) | 10'(off_x_q);
  assign pos_y_o        = (10'(tile_y_q) << OffW) | 10'(off_y_q);
  assign heading_o      = heading_q;
  assign moving_o       = moving_q;
  assign tile_entered_o = tile_entered_q;

endmodule
